// File: rtl/nt_node_pkg.sv
// Shared types and constants for the Nt-node pipe monitor.
package nt_node_pkg;

  // Monitor FSM states; encodings are visible on the state output.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2,
    ALARM = 2'd3
  } state_t;

  // Mode encodings; MODE_RSVD behaves exactly like MODE_PASS.
  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_AND  = 2'b01;
  localparam logic [1:0] MODE_OR   = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  // True for the two modes in which the event monitor is active.
  function automatic logic is_monitor(input logic [1:0] mode);
    return (mode == MODE_AND) || (mode == MODE_OR);
  endfunction

endpackage

// File: rtl/nt_node_lane.sv
// One Nt-node lane: DEPTH-stage input shift chain, captured side input and
// a registered node stage. The output is decoded purely from registers.
module nt_node_lane #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  input  logic side,
  input  logic gate,
  output logic node_out
);

  logic [DEPTH-1:0] s_reg;
  logic             cap_reg;
  logic             node_reg;

  // Advance the chain, capture side and update the node stage when enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_reg    <= '0;
      cap_reg  <= 1'b0;
      node_reg <= 1'b0;
    end else if (en) begin
      s_reg    <= {s_reg[DEPTH-2:0], din};
      cap_reg  <= side;
      node_reg <= (gate & cap_reg) | ~s_reg[DEPTH-1];
    end
  end

  assign node_out = ~node_reg & s_reg[0] & ~cap_reg;

endmodule

// File: rtl/nt_node_pipe_monitor.sv
// WIDTH-lane Nt-node pipeline with a consecutive-event monitor that raises a
// sticky alarm after THRESH back-to-back qualifying cycles.
module nt_node_pipe_monitor
  import nt_node_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8,
  parameter int THRESH = 16
) (
  input  logic             I1470,
  input  logic             I1477,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] side,
  input  logic [WIDTH-1:0] gate,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic [WIDTH-1:0] node_out,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             alarm,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(THRESH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] hit_cnt_reg, hit_cnt_next;
  logic             alarm_reg, alarm_next;
  logic             event_hit;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      nt_node_lane #(.DEPTH(DEPTH)) u_lane (
        .clk      (I1470),
        .rst_n    (I1477),
        .en       (en),
        .din      (din[gi]),
        .side     (side[gi]),
        .gate     (gate[gi]),
        .node_out (node_out[gi])
      );
    end
  endgenerate

  // Reduce lane outputs into the monitor event; pass/reserved never qualify.
  always_comb begin
    event_hit = 1'b0;
    case (mode)
      MODE_AND: event_hit = &node_out;
      MODE_OR:  event_hit = |node_out;
      default:  event_hit = 1'b0;
    endcase
  end

  // Next-state logic: clr wins over everything, otherwise evaluate only on en.
  always_comb begin
    state_next   = state_reg;
    hit_cnt_next = hit_cnt_reg;
    alarm_next   = alarm_reg;
    if (clr) begin
      state_next   = IDLE;
      hit_cnt_next = '0;
      alarm_next   = 1'b0;
    end else if (en) begin
      case (state_reg)
        IDLE: begin
          hit_cnt_next = '0;
          if (is_monitor(mode)) state_next = ARMED;
        end
        ARMED: begin
          if (!is_monitor(mode)) begin
            state_next   = IDLE;
            hit_cnt_next = '0;
          end else if (event_hit) begin
            hit_cnt_next = CNT_ONE;
            if (THRESH == 1) begin
              state_next = ALARM;
              alarm_next = 1'b1;
            end else begin
              state_next = COUNT;
            end
          end
        end
        COUNT: begin
          if (!is_monitor(mode)) begin
            state_next   = IDLE;
            hit_cnt_next = '0;
          end else if (event_hit) begin
            if (hit_cnt_reg == THRESH_M1) begin
              state_next   = ALARM;
              hit_cnt_next = THRESH_C;
              alarm_next   = 1'b1;
            end else begin
              hit_cnt_next = hit_cnt_reg + CNT_ONE;
            end
          end else begin
            // A single quiet cycle breaks the run.
            state_next   = ARMED;
            hit_cnt_next = '0;
          end
        end
        ALARM: begin
          alarm_next = 1'b1;
        end
        default: begin
          state_next   = IDLE;
          hit_cnt_next = '0;
        end
      endcase
    end
  end

  // Monitor state registers with synchronous active-low reset.
  always_ff @(posedge I1470) begin
    if (!I1477) begin
      state_reg   <= IDLE;
      hit_cnt_reg <= '0;
      alarm_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hit_cnt_reg <= hit_cnt_next;
      alarm_reg   <= alarm_next;
    end
  end

  assign hit_cnt = hit_cnt_reg;
  assign alarm   = alarm_reg;
  assign state   = state_reg;

endmodule

// File: tb/tb_nt_node_pipe_monitor.sv
// Scoreboard bench: the driver pushes the expected post-edge outputs for every
// cycle it drives; a monitor pops and compares shortly after each rising edge.
module tb_nt_node_pipe_monitor;

  localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_COUNT = 2'd2, S_ALARM = 2'd3;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] din = 4'h0, side = 4'h0, gate = 4'h0;
  logic       en = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       clr = 1'b0;
  logic [3:0] node_out;
  logic [7:0] hit_cnt;
  logic       alarm;
  logic [1:0] state;

  typedef struct {
    logic [3:0] node;
    logic [7:0] cnt;
    logic       alm;
    logic [1:0] st;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  nt_node_pipe_monitor #(.WIDTH(4), .DEPTH(2), .CNT_W(8), .THRESH(16)) dut (
    .I1470    (clk),
    .I1477    (rstn),
    .din      (din),
    .side     (side),
    .gate     (gate),
    .en       (en),
    .mode     (mode),
    .clr      (clr),
    .node_out (node_out),
    .hit_cnt  (hit_cnt),
    .alarm    (alarm),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s got=%0h want=%0h", nm, fld, act, req);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after its edge.
  task automatic cyc(input logic [3:0] d, input logic [3:0] s, input logic [3:0] g,
                     input logic e, input logic [1:0] m, input logic c, input logic r,
                     input logic [3:0] enode, input logic [7:0] ecnt, input logic ealm,
                     input logic [1:0] est, input string nm);
    exp_t x;
    @(negedge clk);
    din = d; side = s; gate = g; en = e; mode = m; clr = c; rstn = r;
    x.node = enode; x.cnt = ecnt; x.alm = ealm; x.st = est; x.nm = nm;
    q.push_back(x);
  endtask

  // Monitor: compare the registered outputs once they have settled.
  always @(posedge clk) begin
    exp_t x;
    #2;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk(x.nm, "node_out", {4'h0, node_out}, {4'h0, x.node});
      chk(x.nm, "hit_cnt", hit_cnt, x.cnt);
      chk(x.nm, "alarm", {7'h0, alarm}, {7'h0, x.alm});
      chk(x.nm, "state", {6'h0, state}, {6'h0, x.st});
      $display("cycle %-8s node=%h cnt=%0d alarm=%0b state=%0d", x.nm, node_out, hit_cnt, alarm, state);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held two cycles with din all ones.
    cyc(4'hF, 0, 0, 1, 2'b00, 0, 0, 4'h0, 0, 0, S_IDLE, "rst0");
    cyc(4'hF, 0, 0, 1, 2'b00, 0, 0, 4'h0, 0, 0, S_IDLE, "rst1");

    // Pass mode: node_out follows the chain equations, FSM stays idle.
    cyc(4'hF, 0, 0, 1, 2'b00, 0, 1, 4'h0, 0, 0, S_IDLE, "pass1");
    cyc(4'hF, 0, 0, 1, 2'b00, 0, 1, 4'h0, 0, 0, S_IDLE, "pass2");
    cyc(4'hF, 0, 0, 1, 2'b00, 0, 1, 4'hF, 0, 0, S_IDLE, "pass3");
    cyc(4'h0, 0, 0, 1, 2'b00, 0, 1, 4'h0, 0, 0, S_IDLE, "pass4");
    cyc(4'hF, 0, 0, 1, 2'b00, 0, 1, 4'hF, 0, 0, S_IDLE, "pass5");
    cyc(4'hF, 0, 0, 1, 2'b00, 0, 1, 4'h0, 0, 0, S_IDLE, "pass6");
    cyc(4'hF, 0, 0, 1, 2'b00, 0, 1, 4'hF, 0, 0, S_IDLE, "pass7");

    // OR mode, lane 0 only: 16 consecutive events reach the alarm.
    cyc(4'h1, 0, 0, 1, 2'b10, 0, 1, 4'h1, 0, 0, S_ARMED, "or_arm");
    for (int k = 1; k <= 15; k++)
      cyc(4'h1, 0, 0, 1, 2'b10, 0, 1, 4'h1, 8'(k), 0, S_COUNT, $sformatf("or_c%0d", k));
    cyc(4'h1, 0, 0, 1, 2'b10, 0, 1, 4'h1, 16, 1, S_ALARM, "or_alarm");
    cyc(4'h0, 0, 0, 1, 2'b10, 0, 1, 4'h0, 16, 1, S_ALARM, "or_hold1");
    cyc(4'h0, 0, 0, 1, 2'b10, 0, 1, 4'h0, 16, 1, S_ALARM, "or_hold2");
    cyc(4'h0, 0, 0, 1, 2'b10, 1, 1, 4'h0, 0, 0, S_IDLE, "clr1");

    // AND mode: five events then one quiet cycle drops back to ARMED.
    cyc(4'hF, 0, 0, 1, 2'b01, 0, 1, 4'h0, 0, 0, S_ARMED, "and_arm");
    cyc(4'hF, 0, 0, 1, 2'b01, 0, 1, 4'h0, 0, 0, S_ARMED, "and_w1");
    cyc(4'hF, 0, 0, 1, 2'b01, 0, 1, 4'hF, 0, 0, S_ARMED, "and_w2");
    for (int k = 1; k <= 4; k++)
      cyc(4'hF, 0, 0, 1, 2'b01, 0, 1, 4'hF, 8'(k), 0, S_COUNT, $sformatf("and_c%0d", k));
    cyc(4'hE, 0, 0, 1, 2'b01, 0, 1, 4'hE, 5, 0, S_COUNT, "and_c5");
    cyc(4'hF, 0, 0, 1, 2'b01, 0, 1, 4'hF, 0, 0, S_ARMED, "and_quiet");
    cyc(4'hF, 0, 0, 1, 2'b01, 0, 1, 4'hE, 1, 0, S_COUNT, "and_r1");
    cyc(4'hF, 0, 0, 1, 2'b01, 0, 1, 4'hF, 0, 0, S_ARMED, "and_r2");
    for (int k = 1; k <= 7; k++)
      cyc(4'hF, 0, 0, 1, 2'b01, 0, 1, 4'hF, 8'(k), 0, S_COUNT, $sformatf("and_k%0d", k));

    // en=0 freezes the count; clr still acts with en=0.
    for (int k = 0; k < 3; k++)
      cyc(4'h0, 0, 0, 0, 2'b01, 0, 1, 4'hF, 7, 0, S_COUNT, $sformatf("frz%0d", k));
    cyc(4'h0, 0, 0, 0, 2'b01, 1, 1, 4'hF, 0, 0, S_IDLE, "frz_clr");

    // Back to ALARM, hold under pass mode, then clr together with reset.
    cyc(4'hF, 0, 0, 1, 2'b01, 0, 1, 4'hF, 0, 0, S_ARMED, "a2_arm");
    for (int k = 1; k <= 15; k++)
      cyc(4'hF, 0, 0, 1, 2'b01, 0, 1, 4'hF, 8'(k), 0, S_COUNT, $sformatf("a2_c%0d", k));
    cyc(4'hF, 0, 0, 1, 2'b01, 0, 1, 4'hF, 16, 1, S_ALARM, "a2_alarm");
    cyc(4'hF, 0, 0, 1, 2'b00, 0, 1, 4'hF, 16, 1, S_ALARM, "a2_pass");
    cyc(4'hF, 0, 0, 1, 2'b01, 1, 0, 4'h0, 0, 0, S_IDLE, "clr_rst");

    // Mode change to reserved while counting returns to IDLE.
    cyc(4'hF, 0, 0, 1, 2'b01, 0, 1, 4'h0, 0, 0, S_ARMED, "m_arm");
    cyc(4'hF, 0, 0, 1, 2'b01, 0, 1, 4'h0, 0, 0, S_ARMED, "m_w1");
    cyc(4'hF, 0, 0, 1, 2'b01, 0, 1, 4'hF, 0, 0, S_ARMED, "m_w2");
    cyc(4'hF, 0, 0, 1, 2'b01, 0, 1, 4'hF, 1, 0, S_COUNT, "m_c1");
    cyc(4'hF, 0, 0, 1, 2'b01, 0, 1, 4'hF, 2, 0, S_COUNT, "m_c2");
    cyc(4'hF, 0, 0, 1, 2'b11, 0, 1, 4'hF, 0, 0, S_IDLE, "m_rsvd");
    cyc(4'hF, 0, 0, 1, 2'b11, 0, 1, 4'hF, 0, 0, S_IDLE, "m_rsvd2");

    // Side capture masks the output; gate feeds the node stage.
    cyc(4'hF, 4'h5, 4'h0, 1, 2'b00, 0, 1, 4'hA, 0, 0, S_IDLE, "side1");
    cyc(4'hF, 4'h0, 4'hF, 1, 2'b00, 0, 1, 4'hA, 0, 0, S_IDLE, "gate1");
    cyc(4'hF, 4'h0, 4'hF, 1, 2'b00, 0, 1, 4'hF, 0, 0, S_IDLE, "gate2");

    @(negedge clk);
    @(negedge clk);
    chk("drain", "queue", 8'(q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
